// File: rtl/tank_store_r2_if.sv
// Serial tank port bundle: per-digit gates and data in, emerging digit and position out.
// The controller side drives the master modport; the tank itself sits on the slave modport.
interface tank_store_r2_if #(
    parameter int DIG_W = 5,
    parameter int MC_W  = 5
);
    logic             digit_pulse;
    logic             t_in;
    logic             t_out;
    logic             data_in;
    logic             data_out;
    logic [DIG_W-1:0] digit_idx;
    logic [MC_W-1:0]  mc_idx;
    logic             mc_start;
    logic             gate_clash;

    modport master (
        output digit_pulse, t_in, t_out, data_in,
        input  data_out, digit_idx, mc_idx, mc_start, gate_clash
    );

    modport slave (
        input  digit_pulse, t_in, t_out, data_in,
        output data_out, digit_idx, mc_idx, mc_start, gate_clash
    );
endinterface

// File: rtl/tank_store_r2.sv
// Mercury-delay-line emulation: a WORDS*WORD_BITS bit serial loop that recirculates one digit
// per digit_pulse, with gated write (t_in) / read (t_out) and published digit/minor-cycle position.
module tank_store_r2 #(
    parameter int WORD_BITS = 18,
    parameter int WORDS     = 32,
    parameter int DIG_W     = 5,
    parameter int MC_W      = 5
) (
    input  logic          clk,
    input  logic          rst,
    tank_store_r2_if.slave bus
);
    localparam int LEN = WORD_BITS * WORDS;
    localparam logic [DIG_W-1:0] DIG_LAST = DIG_W'(WORD_BITS - 1);
    localparam logic [MC_W-1:0]  MC_LAST  = MC_W'(WORDS - 1);

    logic [LEN-1:0]   line_q,     line_d;
    logic [DIG_W-1:0] digit_q,    digit_d;
    logic [MC_W-1:0]  mc_q,       mc_d;
    logic             data_out_q, data_out_d;
    logic             mc_start_q, mc_start_d;
    logic             clash_q,    clash_d;

    logic tail_bit;
    logic entry_bit;
    logic digit_wrap;
    logic mc_wrap;

    // The oldest bit is the one emerging at (mc_q, digit_q); it re-enters at the head
    // unless a write window replaces it.
    assign tail_bit   = line_q[LEN-1];
    assign entry_bit  = bus.t_in ? bus.data_in : tail_bit;
    assign digit_wrap = (digit_q == DIG_LAST);
    assign mc_wrap    = (mc_q == MC_LAST);

    always_comb begin
        line_d     = line_q;
        digit_d    = digit_q;
        mc_d       = mc_q;
        data_out_d = data_out_q;
        mc_start_d = 1'b0;
        clash_d    = clash_q;

        if (bus.digit_pulse) begin
            line_d     = {line_q[LEN-2:0], entry_bit};
            data_out_d = bus.t_out & tail_bit;
            mc_start_d = digit_wrap;
            if (digit_wrap) begin
                digit_d = '0;
                mc_d    = mc_wrap ? '0 : mc_q + 1'b1;
            end else begin
                digit_d = digit_q + 1'b1;
            end
            // Read still sees the old digit above; only the flag records the overlap.
            if (bus.t_in && bus.t_out) begin
                clash_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_q     <= '0;
            digit_q    <= '0;
            mc_q       <= '0;
            data_out_q <= 1'b0;
            mc_start_q <= 1'b0;
            clash_q    <= 1'b0;
        end else begin
            line_q     <= line_d;
            digit_q    <= digit_d;
            mc_q       <= mc_d;
            data_out_q <= data_out_d;
            mc_start_q <= mc_start_d;
            clash_q    <= clash_d;
        end
    end

    assign bus.data_out   = data_out_q;
    assign bus.digit_idx  = digit_q;
    assign bus.mc_idx     = mc_q;
    assign bus.mc_start   = mc_start_q;
    assign bus.gate_clash = clash_q;
endmodule

// File: tb/tb_tank_store_r2.sv
// Bench for tank_store_r2: word-level vector table plus hand sequences for reset, stall and wrap,
// with a per-digit scoreboard built from a position-indexed tank model.
module tb_tank_store_r2;
    localparam int WB  = 18;
    localparam int NW  = 32;
    localparam int LEN = WB * NW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tank_store_r2_if #(.DIG_W(5), .MC_W(5)) bus ();

    tank_store_r2 #(.WORD_BITS(WB), .WORDS(NW), .DIG_W(5), .MC_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        bit dout;
        bit start;
        int dig;
        int mc;
        bit clash;
    } exp_t;

    typedef struct {
        string       name;
        int          mc;
        bit          ti;
        bit          to;
        logic [17:0] wdata;
        logic [17:0] exp;
        int          laps;
    } vec_t;

    exp_t sbq[$];
    bit   mem [NW][WB];
    int   pos;
    bit   m_dout, m_start, m_clash;
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (pos=%0d)", name, act, exp, pos);
        end
    endtask

    task automatic model_reset();
        foreach (mem[m, d]) mem[m][d] = 1'b0;
        pos     = 0;
        m_dout  = 1'b0;
        m_start = 1'b0;
        m_clash = 1'b0;
        sbq.delete();
    endtask

    // One clock: model predicts, scoreboard queues, DUT is stepped, outputs are compared at negedge.
    task automatic run_pulse(input bit dp, input bit ti, input bit to, input bit di);
        exp_t e;
        if (dp) begin
            int  m    = pos / WB;
            int  d    = pos % WB;
            bit  tail = mem[m][d];
            m_dout = to ? tail : 1'b0;
            if (ti) mem[m][d] = di;
            if (ti && to) m_clash = 1'b1;
            pos     = (pos + 1) % LEN;
            m_start = ((pos % WB) == 0);
        end else begin
            m_start = 1'b0;
        end
        e = '{dout: m_dout, start: m_start, dig: pos % WB, mc: pos / WB, clash: m_clash};
        sbq.push_back(e);
        bus.digit_pulse = dp;
        bus.t_in        = ti;
        bus.t_out       = to;
        bus.data_in     = di;
        @(posedge clk);
        @(negedge clk);
        bus.digit_pulse = 1'b0;
        bus.t_in        = 1'b0;
        bus.t_out       = 1'b0;
        e = sbq.pop_front();
        check("data_out",   int'(bus.data_out),   int'(e.dout));
        check("digit_idx",  int'(bus.digit_idx),  e.dig);
        check("mc_idx",     int'(bus.mc_idx),     e.mc);
        check("mc_start",   int'(bus.mc_start),   int'(e.start));
        check("gate_clash", int'(bus.gate_clash), int'(e.clash));
    endtask

    task automatic idle_to(input int mc);
        while (pos != mc * WB) run_pulse(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic word_op(input int mc, input bit ti, input bit to, input logic [17:0] wdata,
                           output logic [17:0] rd);
        idle_to(mc);
        rd = '0;
        for (int d = 0; d < WB; d++) begin
            run_pulse(1'b1, ti, to, wdata[d]);
            rd[d] = bus.data_out;
        end
    endtask

    initial begin
        vec_t        tbl [8];
        logic [17:0] rd;
        int          starts;
        int          ones;
        bit          wrap_seen;
        int          prev_mc;
        logic [17:0] nodata;

        tbl[0] = '{name: "wr_mc5",     mc: 5, ti: 1, to: 0, wdata: 18'h1A5A5, exp: 18'h0,     laps: 0};
        tbl[1] = '{name: "rd_mc5",     mc: 5, ti: 0, to: 1, wdata: 18'h0,     exp: 18'h1A5A5, laps: 0};
        tbl[2] = '{name: "wr_mc0",     mc: 0, ti: 1, to: 0, wdata: 18'h3FFFF, exp: 18'h0,     laps: 0};
        tbl[3] = '{name: "recirc_mc0", mc: 0, ti: 0, to: 1, wdata: 18'h0,     exp: 18'h3FFFF, laps: 3};
        tbl[4] = '{name: "rd_mc1",     mc: 1, ti: 0, to: 1, wdata: 18'h0,     exp: 18'h0,     laps: 0};
        tbl[5] = '{name: "wr_mc2",     mc: 2, ti: 1, to: 0, wdata: 18'h000FF, exp: 18'h0,     laps: 0};
        tbl[6] = '{name: "clash_mc2",  mc: 2, ti: 1, to: 1, wdata: 18'h3FF00, exp: 18'h000FF, laps: 0};
        tbl[7] = '{name: "rd_mc2",     mc: 2, ti: 0, to: 1, wdata: 18'h0,     exp: 18'h3FF00, laps: 0};

        bus.digit_pulse = 1'b0;
        bus.t_in        = 1'b0;
        bus.t_out       = 1'b0;
        bus.data_in     = 1'b0;
        nodata          = '0;
        model_reset();

        // Power-on reset values
        repeat (3) @(negedge clk);
        check("rst_data_out",   int'(bus.data_out),   0);
        check("rst_digit_idx",  int'(bus.digit_idx),  0);
        check("rst_mc_idx",     int'(bus.mc_idx),     0);
        check("rst_mc_start",   int'(bus.mc_start),   0);
        check("rst_gate_clash", int'(bus.gate_clash), 0);
        rst = 1'b0;
        @(negedge clk);
        $display("txn reset_release pos=%0d", pos);

        // Word-level table
        for (int i = 0; i < 8; i++) begin
            repeat (tbl[i].laps * LEN) run_pulse(1'b1, 1'b0, 1'b0, 1'b0);
            word_op(tbl[i].mc, tbl[i].ti, tbl[i].to, tbl[i].wdata, rd);
            if (tbl[i].to) check(tbl[i].name, int'(rd), int'(tbl[i].exp));
            $display("txn %s mc=%0d t_in=%0d t_out=%0d wdata=%05h rdata=%05h",
                     tbl[i].name, tbl[i].mc, tbl[i].ti, tbl[i].to, tbl[i].wdata, rd);
        end
        check("clash_sticky", int'(bus.gate_clash), 1);

        // Stall mid-word with data_out = 1 and gates active
        idle_to(0);
        repeat (9) run_pulse(1'b1, 1'b0, 1'b1, 1'b0);
        check("pre_stall_dout", int'(bus.data_out), 1);
        for (int k = 0; k < 10; k++) run_pulse(1'b0, 1'b1, 1'b1, k[0]);
        check("stall_digit", int'(bus.digit_idx), 9);
        check("stall_mc",    int'(bus.mc_idx),    0);
        $display("txn stall_mid digit=%0d mc=%0d dout=%0d", bus.digit_idx, bus.mc_idx, bus.data_out);

        // Stall right after a minor-cycle start pulse: mc_start must drop
        idle_to(3);
        check("boundary_start", int'(bus.mc_start), 1);
        repeat (3) run_pulse(1'b0, 1'b0, 1'b0, 1'b0);
        $display("txn stall_boundary mc_start=%0d", bus.mc_start);

        // Full circulation: 32 mc_start pulses, 31 -> 0 wrap
        starts    = 0;
        wrap_seen = 1'b0;
        prev_mc   = int'(bus.mc_idx);
        for (int k = 0; k < LEN; k++) begin
            run_pulse(1'b1, 1'b0, 1'b0, 1'b0);
            if (bus.mc_start) starts++;
            if (prev_mc == NW - 1 && int'(bus.mc_idx) == 0) wrap_seen = 1'b1;
            prev_mc = int'(bus.mc_idx);
        end
        check("mc_start_count", starts, NW);
        check("mc_wrap_seen",   int'(wrap_seen), 1);
        $display("txn wrap starts=%0d wrap_seen=%0d", starts, wrap_seen);

        // Reset mid-word at mc 3 digit 7 with data_out = 1 and clash set
        word_op(3, 1'b1, 1'b0, 18'h3FFFF, rd);
        idle_to(3);
        repeat (7) run_pulse(1'b1, 1'b0, 1'b1, 1'b0);
        check("pre_rst_dout",  int'(bus.data_out),  1);
        check("pre_rst_digit", int'(bus.digit_idx), 7);
        #2 rst = 1'b1;
        #1;
        check("arst_data_out",   int'(bus.data_out),   0);
        check("arst_digit_idx",  int'(bus.digit_idx),  0);
        check("arst_mc_idx",     int'(bus.mc_idx),     0);
        check("arst_mc_start",   int'(bus.mc_start),   0);
        check("arst_gate_clash", int'(bus.gate_clash), 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        ones = 0;
        for (int k = 0; k < LEN; k++) begin
            run_pulse(1'b1, 1'b0, 1'b1, 1'b0);
            if (bus.data_out) ones++;
        end
        check("post_rst_line_clear", ones, 0);
        $display("txn reset_mid ones_read=%0d", ones);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
